// File: rtl/reg_file_wb.sv
// Write-back register file: 32 x DATA_W storage, r0 hardwired to zero, two combinational
// read ports and a saturating committed-write counter. Optional macro: REG_FILE_WB_BYPASS_EN.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [0:ADDR_W-1] write_reg,
  input  logic [0:DATA_W-1] write_data,
  input  logic [0:ADDR_W-1] read_reg1,
  input  logic [0:ADDR_W-1] read_reg2,
  output logic [0:DATA_W-1] read_data1,
  output logic [0:DATA_W-1] read_data2,
  output logic [0:15]       write_count
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   wr_en_oh;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;

  // One-hot write enable; bit 0 is always masked so r0 can never be written.
  function automatic logic [NREG-1:0] decode_wr(input logic en,
                                                input logic [ADDR_W-1:0] addr);
    logic [NREG-1:0] oh;
    oh = '0;
    if (en) oh[addr] = 1'b1;
    oh[0] = 1'b0;
    return oh;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = (addr == '0) ? '0 : regs_q[addr];
`ifdef REG_FILE_WB_BYPASS_EN
    if (reg_write && !rst && (write_reg != '0) && (addr == write_reg))
      val = write_data;
`endif
    return val;
  endfunction

  assign wr_en_oh = decode_wr(reg_write, write_reg);

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr_en_oh[i]) regs_d[i] = write_data;
    end
    cnt_d = (|wr_en_oh) ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign read_data1  = rd_port(read_reg1);
  assign read_data2  = rd_port(read_reg2);
  assign write_count = cnt_q;

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Write-back destination side of the datapath: takes the 5-bit destination register number and 32-bit result chosen by the write-back selectors and decodes them into one of 32 architectural registers.
- Provides two combinational read ports for the decode stage.
- Register 0 is hardwired to zero.
- Sits between the write-back selectors and the ALU operand inputs.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register-number width; register count = 2**ADDR_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- reg_write  input  1  write enable from control unit.
- write_reg  input  ADDR_W  destination register number (decoded one-hot internally).
- write_data  input  DATA_W  result to store.
- read_reg1  input  ADDR_W  source register number, port 1 (rs).
- read_reg2  input  ADDR_W  source register number, port 2 (rt).
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.
- write_count  output  16  number of committed writes since reset, saturating.

Port vectors use the datapath's [0:N-1] bit ordering; bit 0 is MSB.

Behaviour:
- Reset (synchronous, rst=1 at rising clk):
  - All 32 registers are cleared to 0.
  - write_count is cleared to 0.
  - rst takes priority over reg_write in the same cycle; no write occurs.
- Write decode:
  - write_reg is decoded to a 32-bit one-hot enable vector.
  - On a rising edge with rst=0 and reg_write=1, the register selected by write_reg takes write_data.
  - All other registers hold their value.
- Register 0:
  - A write with write_reg=0 is discarded; register 0 always reads 0.
  - A write to register 0 does not increment write_count.
- Reads:
  - Purely combinational from current register state, with zero-cycle latency.
  - read_reg=0 returns 0.
  - Without the optional feature, a write and a read of the same register in the same cycle returns the OLD value. The new value is visible the cycle after the edge.
  - Both ports may address the same register; each independently returns its value.
- write_count:
  - Increments by 1 on each committed write to registers 1..31.
  - Saturates at 16'hFFFF; no wrap-around.
- reg_write with X or Z on write_reg is a protocol error. The bench flags it; RTL behaviour is unspecified.
- Reset asserted mid-program: the state clears at that edge and no partial write occurs. Reads in the reset cycle show pre-reset contents; reads from the next cycle show 0.
- No other state. There is no FSM: the block is a decoded storage array plus a saturating counter.

Optional Feature:
- Macro: REG_FILE_WB_BYPASS_EN.
- Defined:
  - Internal write-before-read forwarding.
  - If reg_write=1, rst=0, write_reg!=0 and read_regN==write_reg, read_dataN presents write_data combinationally in the same cycle.
  - This lets a same-cycle write and read of one register return the new value without a separate forwarding mux in the datapath.
- Not defined: reads always return the stored (pre-edge) value as stated above.
- Register 0 still reads 0 in both builds.

Test Plan:
- Reset → all zero: preload r5=32'hDEADBEEF, assert rst 1 cycle → read_reg1=5 gives 0, write_count=0.
- Basic write/read: reg_write=1, write_reg=9, write_data=32'h12345678 for one edge, then read_reg1=9, read_reg2=9 → both read_data=32'h12345678, write_count=1.
- Zero register: write_reg=0, write_data=32'hFFFFFFFF, reg_write=1 → read_reg1=0 gives 0, write_count unchanged.
- Same-cycle read/write of r3 (old=32'h1, new=32'h2):
  - Without REG_FILE_WB_BYPASS_EN → read_data1=32'h1 before the edge, 32'h2 after.
  - With REG_FILE_WB_BYPASS_EN → read_data1=32'h2 in the same cycle.
- Reset priority: rst=1 and reg_write=1, write_reg=7, write_data=32'hA5A5A5A5 on the same edge → r7 reads 0 afterwards, write_count=0.
- Full sweep and saturation:
  - Write r1..r31 with value=index×32'h01010101, then read all 31 back on both ports → every value matches.
  - Force 70000 writes → write_count holds at 16'hFFFF.
